row_config_loader: RTL
======================

Name: row_config_loader

Overview:
- Configuration controller for one odd/even fabric row of 8 configurable cells, each taking 69 programming bits (552 bits total).
- Accepts the row bitstream as 32-bit words over a valid/ready stream and assembles them in a shadow register.
- Checks an XOR trailer word, then commits the shadow atomically to the row's prog bus, so cells never see a partially loaded configuration.
- Sits between the device configuration port and the row's prog input.

Parameters:
- NUM_CELLS, 8, cells per row.
- CELL_W, 69, prog bits per cell.
- PROG_W, 552, NUM_CELLS*CELL_W; row prog width.
- WORD_W, 32, configuration word width.
- NUM_WORDS, 18, ceil(PROG_W/WORD_W); data words per frame, excluding the trailer.

Ports:
- clb_clk  in  1  fabric/configuration clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  single-cycle frame start request.
- cfg_abort  in  1  abandon the current frame.
- cfg_data  in  32  configuration word.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader accepts a word this cycle.
- prog  out  552  committed row configuration; bit 551 is the MSB of cell 1's field.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on successful commit.
- err  out  1  sticky checksum error.
- word_cnt  out  5  number of data words accepted in the current frame.

Behaviour:
- Reset values: prog=0, cfg_ready=0, busy=0, done=0, err=0, word_cnt=0, shadow=0, xor_acc=0, state=IDLE.
- Handshake: a word transfers on a clock edge where cfg_valid && cfg_ready. cfg_ready is a function of state only (1 in LOAD and CHK), never of cfg_valid.
- IDLE:
  - cfg_start: go to LOAD; clear word_cnt, xor_acc and err; shadow is not cleared.
  - busy=0.
- LOAD:
  - Word k (k=0..17) writes shadow[551-32k -: 32]; xor_acc ^= cfg_data; word_cnt++.
  - Word 17 covers only prog[7:0]: cfg_data[31:24] go to shadow[7:0], cfg_data[23:0] are discarded, but the full 32 bits still enter xor_acc.
  - After word 17 is accepted, go to CHK.
- CHK:
  - The next accepted word is the trailer.
  - trailer == xor_acc: go to COMMIT. Otherwise go to ERR.
- COMMIT (one cycle, cfg_ready=0): prog<=shadow, done<=1, go to IDLE.
- ERR (one cycle, cfg_ready=0): err<=1, prog unchanged, go to IDLE.
- busy=1 in LOAD, CHK, COMMIT and ERR.
- Latency: trailer handshake at edge E; prog updates and done rises at edge E+1; done falls at edge E+2.
- cfg_abort:
  - In LOAD or CHK it goes to IDLE at the next edge; prog and err unchanged; no done.
  - Abort wins over a simultaneous valid word, which is not consumed.
  - Ignored in COMMIT and ERR, which complete.
- cfg_start while busy: ignored. cfg_start and cfg_abort together in IDLE: remain IDLE.
- cfg_valid while idle: no transfer (cfg_ready=0).
- word_cnt saturates at 18 and holds through CHK.
- Reset mid-frame: immediately returns all state and prog to reset values.
- prog is held stable at all times except the single COMMIT edge.
- The clock is never gated by this block.

Test Plan:
- Good frame: start, then 18 words of 0xA5A5A5A5 and trailer 0x00000000 with cfg_valid held high. Required: cfg_ready high for 19 cycles; done pulses once, 2 edges after the trailer; prog = 69 bytes of 0xA5; err=0.
- Partial last word: words 0..16 = 0, word 17 = 0x3C123456, trailer 0x3C123456. Required: prog[7:0]=0x3C; all other prog bits 0; done=1.
- Bad checksum: frame of case 1 already committed; new frame of 18 words of 0xFFFFFFFF with trailer 0x00000001. Required: err=1, done never asserts, prog still all 0xA5; next cfg_start clears err.
- Abort: after 7 words, assert cfg_abort together with cfg_valid. Required: word_cnt stays 7 at the abort edge; IDLE next cycle; prog unchanged; a following start plus a full good frame commits correctly.
- Backpressure and start collision: random cfg_valid gaps with a cfg_start pulse mid-LOAD. Required: start ignored; same committed result as case 1.
- Async reset: assert rst mid-CHK between clock edges. Required: prog=0, busy=0, cfg_ready=0 immediately, without waiting for clb_clk.

Source files
------------

// File: rtl/row_config_loader.sv
// Row configuration loader. Assembles a frame of 32-bit words into a shadow
// register, checks it against an XOR trailer word, and then commits the
// shadow to the row's prog bus in a single edge. The cells never see a
// partially loaded configuration.
module row_config_loader #(
    parameter int NUM_CELLS = 8,
    parameter int CELL_W    = 69,
    parameter int PROG_W    = NUM_CELLS * CELL_W,
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = (PROG_W + WORD_W - 1) / WORD_W
) (
    input  logic              clb_clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [PROG_W-1:0] prog,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [4:0]        word_cnt
);

    // The last data word only partly overlaps the row. Its top LAST_W bits
    // land in the low end of prog, and the rest of the word is padding.
    localparam int         LAST_W   = PROG_W - WORD_W * (NUM_WORDS - 1);
    localparam logic [4:0] LAST_IDX = 5'(NUM_WORDS - 1);
    localparam logic [4:0] FULL_CNT = 5'(NUM_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHK    = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    // Running checksum update for the frame.
    function automatic logic [WORD_W-1:0] xor_fold(
        input logic [WORD_W-1:0] acc,
        input logic [WORD_W-1:0] data
    );
        return acc ^ data;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic                start_s;
    logic                load_acc_s;
    logic [PROG_W-1:0]   shadow_r;
    logic [WORD_W-1:0]   xor_acc_r;
    logic [4:0]          word_cnt_r;
    logic                cfg_ready_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic [PROG_W-1:0]   prog_r;

    // Next-state decode. Abort has priority over a word that arrives in the
    // same cycle, so that word is not consumed.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        load_acc_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start && !cfg_abort) begin
                    state_nxt_s = ST_LOAD;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cfg_abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (cfg_valid) begin
                    load_acc_s = 1'b1;
                    if (word_cnt_r == LAST_IDX) begin
                        state_nxt_s = ST_CHK;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_CHK: begin
                if (cfg_abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (cfg_valid) begin
                    if (cfg_data == xor_acc_r) begin
                        state_nxt_s = ST_COMMIT;
                    end else begin
                        state_nxt_s = ST_ERR;
                    end
                end else begin
                    state_nxt_s = ST_CHK;
                end
            end
            ST_COMMIT: state_nxt_s = ST_IDLE;
            ST_ERR:    state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clb_clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake and status flags. They are registered from the next state,
    // so each one depends only on the current state.
    always_ff @(posedge clb_clk or posedge rst) begin
        if (rst) begin
            cfg_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cfg_ready_r <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_CHK);
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_r == ST_COMMIT);
        end
    end

    // Sticky checksum error. It is cleared only when a new frame starts.
    always_ff @(posedge clb_clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (start_s) begin
            err_r <= 1'b0;
        end else if (state_r == ST_ERR) begin
            err_r <= 1'b1;
        end
    end

    // Word counter and running checksum for the frame in progress.
    always_ff @(posedge clb_clk or posedge rst) begin
        if (rst) begin
            word_cnt_r <= 5'd0;
            xor_acc_r  <= {WORD_W{1'b0}};
        end else if (start_s) begin
            word_cnt_r <= 5'd0;
            xor_acc_r  <= {WORD_W{1'b0}};
        end else if (load_acc_s) begin
            xor_acc_r <= xor_fold(xor_acc_r, cfg_data);
            if (word_cnt_r != FULL_CNT) begin
                word_cnt_r <= word_cnt_r + 5'd1;
            end
        end
    end

    // Shadow assembly, MSB first. It is deliberately not cleared at frame
    // start, because every bit is overwritten before a commit can happen.
    always_ff @(posedge clb_clk or posedge rst) begin
        if (rst) begin
            shadow_r <= {PROG_W{1'b0}};
        end else if (load_acc_s) begin
            for (int i = 0; i < NUM_WORDS - 1; i++) begin
                if (word_cnt_r == 5'(i)) begin
                    shadow_r[PROG_W-1-WORD_W*i -: WORD_W] <= cfg_data;
                end
            end
            if (word_cnt_r == LAST_IDX) begin
                shadow_r[LAST_W-1:0] <= cfg_data[WORD_W-1 -: LAST_W];
            end
        end
    end

    // Atomic commit. prog changes only on the edge that leaves COMMIT.
    always_ff @(posedge clb_clk or posedge rst) begin
        if (rst) begin
            prog_r <= {PROG_W{1'b0}};
        end else if (state_r == ST_COMMIT) begin
            prog_r <= shadow_r;
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign word_cnt  = word_cnt_r;
    assign prog      = prog_r;

endmodule
